// File: rtl/seg7_scan_if.sv
// seg7_scan_if: bundles the segment bus, the clear strobe and the decoder results
//   seg_n       active-low segments, bit6=a .. bit0=g
//   dig_sel_n   active-low digit selects, one-hot expected
//   clr         synchronous clear of captured state
//   digits      decoded nibbles, digit i at [4i+3:4i]
//   valid       per-digit legal-hex flag
//   frame_done  one-cycle pulse when all digits have been committed
//   err         one-cycle pulse on commit of an illegal pattern
//   err_pattern last illegal seg_n value
interface seg7_scan_if #(parameter int NDIG = 8);
  logic [6:0] seg_n;
  logic [NDIG-1:0] dig_sel_n;
  logic clr;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0] valid;
  logic frame_done;
  logic err;
  logic [6:0] err_pattern;
  modport master (output seg_n, dig_sel_n, clr, input digits, valid, frame_done, err, err_pattern);
  modport slave (input seg_n, dig_sel_n, clr, output digits, valid, frame_done, err, err_pattern);
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers hex digits from a multiplexed active-low 7-segment bus
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    seg7_scan_if slave: segment/select inputs and clr in, decoded digits and status out
module seg7_scan_decoder #(
  parameter int NDIG = 8,
  parameter int STABLE_CYC = 4
) (
  input logic clk,
  input logic rst_n,
  seg7_scan_if.slave bus
);
  localparam logic [3:0] SC = 4'(STABLE_CYC);
  logic [NDIG+6:0] prev;
  logic [3:0] cnt, cnt_nxt, val;
  logic [NDIG-1:0] sel, seen, seen_nxt, valid;
  logic [4*NDIG-1:0] digits;
  logic [6:0] err_pattern;
  logic legal, same, commit, hit, blank, frame_done, err;
  assign sel = ~bus.dig_sel_n;
  assign legal = $onehot(sel);
  assign same = {bus.dig_sel_n, bus.seg_n} == prev;
  assign cnt_nxt = !legal ? 4'd0 : !same ? 4'd1 : cnt == SC ? cnt : cnt + 4'd1;
  // a changed sample restarts the run at 1, so it can only commit when one sample is enough
  assign commit = legal && (same ? (cnt != SC && cnt + 4'd1 == SC) : SC == 4'd1);
  assign blank = bus.seg_n == 7'h7F;
  assign seen_nxt = seen | sel;
  always_comb begin
    hit = 1'b1;
    val = 4'h0;
    case (bus.seg_n)
      7'h01: val = 4'h0;
      7'h4F: val = 4'h1;
      7'h12: val = 4'h2;
      7'h06: val = 4'h3;
      7'h4C: val = 4'h4;
      7'h24: val = 4'h5;
      7'h20: val = 4'h6;
      7'h0F: val = 4'h7;
      7'h00: val = 4'h8;
      7'h04: val = 4'h9;
      7'h08: val = 4'hA;
      7'h60: val = 4'hB;
      7'h31: val = 4'hC;
      7'h42: val = 4'hD;
      7'h30: val = 4'hE;
      7'h38: val = 4'hF;
      default: hit = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '1;
      cnt <= '0;
      seen <= '0;
      valid <= '0;
      digits <= '0;
      frame_done <= 1'b0;
      err <= 1'b0;
      err_pattern <= 7'h7F;
    end else if (bus.clr) begin
      prev <= '1;
      cnt <= '0;
      seen <= '0;
      valid <= '0;
      digits <= '0;
      frame_done <= 1'b0;
      err <= 1'b0;
    end else begin
      prev <= {bus.dig_sel_n, bus.seg_n};
      cnt <= cnt_nxt;
      frame_done <= commit && &seen_nxt;
      err <= commit && !hit && !blank;
      if (commit) begin
        seen <= &seen_nxt ? '0 : seen_nxt;
        if (!hit && !blank) err_pattern <= bus.seg_n;
        for (int i = 0; i < NDIG; i++)
          if (sel[i]) begin
            valid[i] <= hit;
            if (hit) digits[4*i +: 4] <= val;
          end
      end
    end
  end
  assign bus.digits = digits;
  assign bus.valid = valid;
  assign bus.frame_done = frame_done;
  assign bus.err = err;
  assign bus.err_pattern = err_pattern;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed vectors against hand-computed results for seg7_scan_decoder
module tb_seg7_scan_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  int n_err = 0;
  int n_fd = 0;
  logic [6:0] pat [8] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F};
  seg7_scan_if #(.NDIG(8)) bus ();
  seg7_scan_decoder #(.NDIG(8), .STABLE_CYC(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic hold(input logic [7:0] sel, input logic [6:0] seg, input int n);
    bus.dig_sel_n = sel;
    bus.seg_n = seg;
    repeat (n) begin
      @(posedge clk);
      #1;
      n_err += int'(bus.err);
      n_fd += int'(bus.frame_done);
    end
  endtask
  task automatic scan(input int first, input int last);
    for (int d = first; d <= last; d++) hold(~8'(1 << d), pat[d], 5);
  endtask
  task automatic pulse_clr();
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    n_err += int'(bus.err);
    n_fd += int'(bus.frame_done);
    bus.clr = 1'b0;
  endtask
  initial begin
    bus.seg_n = 7'h7F;
    bus.dig_sel_n = 8'hFF;
    bus.clr = 1'b0;
    #12;
    chk("rst_digits", bus.digits, 32'h0);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_fd", 32'(bus.frame_done), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_errpat", 32'(bus.err_pattern), 32'h7F);
    #11 rst_n = 1'b1;
    hold(8'hFE, 7'h12, 3);
    chk("d0_early", 32'(bus.valid), 32'h0);
    hold(8'hFE, 7'h12, 1);
    chk("d0_val", 32'(bus.digits[3:0]), 32'h2);
    chk("d0_valid", 32'(bus.valid), 32'h01);
    hold(8'hFE, 7'h12, 6);
    chk("d0_hold_err", 32'(n_err), 32'h0);
    chk("d0_hold_fd", 32'(n_fd), 32'h0);
    hold(8'hFD, 7'h06, 3);
    hold(8'hFD, 7'h4C, 3);
    chk("d1_early_valid", 32'(bus.valid), 32'h01);
    chk("d1_no3", 32'(bus.digits[7:4]), 32'h0);
    hold(8'hFD, 7'h4C, 1);
    chk("d1_val", 32'(bus.digits[7:4]), 32'h4);
    chk("d1_valid", 32'(bus.valid), 32'h03);
    hold(8'hF7, 7'h7E, 4);
    chk("bad_err", 32'(bus.err), 32'h1);
    chk("bad_pat", 32'(bus.err_pattern), 32'h7E);
    chk("bad_valid", 32'(bus.valid), 32'h03);
    chk("bad_digit", 32'(bus.digits[15:12]), 32'h0);
    hold(8'hF7, 7'h7E, 3);
    chk("bad_once", 32'(n_err), 32'h1);
    n_err = 0;
    n_fd = 0;
    scan(0, 6);
    chk("scan_no_fd_early", 32'(n_fd), 32'h0);
    scan(7, 7);
    chk("scan_fd_once", 32'(n_fd), 32'h1);
    chk("scan_digits", bus.digits, 32'h76543210);
    chk("scan_valid", 32'(bus.valid), 32'hFF);
    chk("scan_err", 32'(n_err), 32'h0);
    n_fd = 0;
    hold(8'hFC, 7'h00, 8);
    chk("multi_digits", bus.digits, 32'h76543210);
    chk("multi_valid", 32'(bus.valid), 32'hFF);
    chk("multi_err", 32'(n_err), 32'h0);
    chk("multi_fd", 32'(n_fd), 32'h0);
    scan(0, 3);
    pulse_clr();
    chk("clr_digits", bus.digits, 32'h0);
    chk("clr_valid", 32'(bus.valid), 32'h0);
    chk("clr_fd", 32'(bus.frame_done), 32'h0);
    scan(4, 7);
    chk("clr_seen_cleared", 32'(n_fd), 32'h0);
    scan(0, 3);
    chk("clr_next_frame", 32'(n_fd), 32'h1);
    chk("clr_next_digits", bus.digits, 32'h76543210);
    hold(8'hEF, 7'h08, 2);
    rst_n = 1'b0;
    #3;
    chk("mid_rst_digits", bus.digits, 32'h0);
    chk("mid_rst_errpat", 32'(bus.err_pattern), 32'h7F);
    rst_n = 1'b1;
    hold(8'hEF, 7'h08, 3);
    chk("mid_rst_early", 32'(bus.valid), 32'h0);
    hold(8'hEF, 7'h08, 1);
    chk("mid_rst_val", 32'(bus.digits[19:16]), 32'hA);
    chk("mid_rst_valid", 32'(bus.valid), 32'h10);
    n_err = 0;
    hold(8'hEF, 7'h7F, 4);
    chk("blank_valid", 32'(bus.valid), 32'h0);
    chk("blank_digit", 32'(bus.digits[19:16]), 32'hA);
    chk("blank_err", 32'(n_err), 32'h0);
    hold(8'hDF, 7'h30, 3);
    pulse_clr();
    chk("clr_prio_valid", 32'(bus.valid), 32'h0);
    chk("clr_prio_digits", bus.digits, 32'h0);
    hold(8'hDF, 7'h30, 3);
    chk("clr_restart_early", 32'(bus.valid), 32'h0);
    hold(8'hDF, 7'h30, 1);
    chk("clr_restart_val", 32'(bus.digits[23:20]), 32'hE);
    chk("clr_restart_valid", 32'(bus.valid), 32'h20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
